// File: rtl/l1i_miss_refill_unit.sv
// ============================================================================
// l1i_miss_refill_unit : single-outstanding L1I miss refill from L2 beats
// Rev 1.0
// ============================================================================
`default_nettype none

module l1i_miss_refill_unit #(
  parameter int fetchingAddressWidth = 64,
  parameter int cacheLineWith        = 512,
  parameter int offsetWidth          = 6,
  parameter int beatWidth            = 128,
  parameter int PidSize              = 20,
  parameter int TidSize              = 16
) (
  input  logic                            clock_i,
  input  logic                            reset_i,
  input  logic                            cacheMiss_i,
  input  logic [fetchingAddressWidth-1:0] missedAddress_i,
  input  logic [PidSize-1:0]              missedPid_i,
  input  logic [TidSize-1:0]              missedTid_i,
  output logic                            busy_o,
  output logic                            l2ReqValid_o,
  output logic [fetchingAddressWidth-1:0] l2ReqAddress_o,
  input  logic                            l2ReqReady_i,
  input  logic                            l2RespValid_i,
  input  logic [beatWidth-1:0]            l2RespData_i,
  output logic                            cacheUpdate_o,
  output logic [fetchingAddressWidth-1:0] cacheUpdateAddress_o,
  output logic [cacheLineWith-1:0]        cacheUpdateLine_o,
  output logic [PidSize-1:0]              cacheUpdatePid_o,
  output logic [TidSize-1:0]              cacheUpdateTid_o
);

  localparam int BEATS      = cacheLineWith / beatWidth;
  localparam int BEAT_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_FILL   = 2'd2,
    S_UPDATE = 2'd3
  } state_e;

  state_e                            state_q, state_d;
  logic [BEAT_CNT_W-1:0]             beat_q;
  logic [fetchingAddressWidth-1:0]   addr_q;
  logic [PidSize-1:0]                pid_q;
  logic [TidSize-1:0]                tid_q;
  logic [cacheLineWith-1:0]          line_q;
  logic [fetchingAddressWidth-1:0]   upd_addr_q;
  logic [PidSize-1:0]                upd_pid_q;
  logic [TidSize-1:0]                upd_tid_q;

  logic w_capture;
  logic w_beat_we;
  logic w_last_beat;

  always_comb begin
    state_d     = state_q;
    w_capture   = 1'b0;
    w_beat_we   = 1'b0;
    w_last_beat = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cacheMiss_i) begin
          w_capture = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (l2ReqReady_i) state_d = S_FILL;
      end
      S_FILL: begin
        if (l2RespValid_i) begin
          w_beat_we = 1'b1;
          if (beat_q == LAST_BEAT) begin
            w_last_beat = 1'b1;
            state_d     = S_UPDATE;
          end
        end
      end
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      beat_q     <= '0;
      addr_q     <= '0;
      pid_q      <= '0;
      tid_q      <= '0;
      line_q     <= '0;
      upd_addr_q <= '0;
      upd_pid_q  <= '0;
      upd_tid_q  <= '0;
    end else begin
      if (w_capture) begin
        addr_q <= {missedAddress_i[fetchingAddressWidth-1:offsetWidth], {offsetWidth{1'b0}}};
        pid_q  <= missedPid_i;
        tid_q  <= missedTid_i;
      end
      // Beat 0 lands at the most-significant end of the line.
      if (w_beat_we) begin
        beat_q <= w_last_beat ? '0 : beat_q + 1'b1;
        for (int b = 0; b < BEATS; b++) begin
          if (beat_q == BEAT_CNT_W'(b)) begin
            line_q[cacheLineWith-1-b*beatWidth -: beatWidth] <= l2RespData_i;
          end
        end
      end
      // Update-side tags are latched separately so they stay stable across later misses.
      if (w_last_beat) begin
        upd_addr_q <= addr_q;
        upd_pid_q  <= pid_q;
        upd_tid_q  <= tid_q;
      end
    end
  end

  assign busy_o               = (state_q != S_IDLE);
  assign l2ReqValid_o         = (state_q == S_REQ);
  assign l2ReqAddress_o       = addr_q;
  assign cacheUpdate_o        = (state_q == S_UPDATE);
  assign cacheUpdateAddress_o = upd_addr_q;
  assign cacheUpdateLine_o    = line_q;
  assign cacheUpdatePid_o     = upd_pid_q;
  assign cacheUpdateTid_o     = upd_tid_q;

endmodule

`default_nettype wire

// File: tb/tb_l1i_miss_refill_unit.sv
// ============================================================================
// tb_l1i_miss_refill_unit : vector table + scoreboard bench for the refill unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_l1i_miss_refill_unit;

  logic         clock_i = 1'b0;
  logic         reset_i = 1'b0;
  logic         cacheMiss_i = 1'b0;
  logic [63:0]  missedAddress_i = '0;
  logic [19:0]  missedPid_i = '0;
  logic [15:0]  missedTid_i = '0;
  logic         busy_o;
  logic         l2ReqValid_o;
  logic [63:0]  l2ReqAddress_o;
  logic         l2ReqReady_i = 1'b0;
  logic         l2RespValid_i = 1'b0;
  logic [127:0] l2RespData_i = '0;
  logic         cacheUpdate_o;
  logic [63:0]  cacheUpdateAddress_o;
  logic [511:0] cacheUpdateLine_o;
  logic [19:0]  cacheUpdatePid_o;
  logic [15:0]  cacheUpdateTid_o;

  l1i_miss_refill_unit dut (
    .clock_i              (clock_i),
    .reset_i              (reset_i),
    .cacheMiss_i          (cacheMiss_i),
    .missedAddress_i      (missedAddress_i),
    .missedPid_i          (missedPid_i),
    .missedTid_i          (missedTid_i),
    .busy_o               (busy_o),
    .l2ReqValid_o         (l2ReqValid_o),
    .l2ReqAddress_o       (l2ReqAddress_o),
    .l2ReqReady_i         (l2ReqReady_i),
    .l2RespValid_i        (l2RespValid_i),
    .l2RespData_i         (l2RespData_i),
    .cacheUpdate_o        (cacheUpdate_o),
    .cacheUpdateAddress_o (cacheUpdateAddress_o),
    .cacheUpdateLine_o    (cacheUpdateLine_o),
    .cacheUpdatePid_o     (cacheUpdatePid_o),
    .cacheUpdateTid_o     (cacheUpdateTid_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic [63:0]  addr;
    logic [19:0]  pid;
    logic [15:0]  tid;
    int           ready_delay;
    int           gap;
    bit           stray;
    bit           busy_miss;
    bit           upd_miss;
    logic [63:0]  exp_addr;
    logic [511:0] line;
  } vec_t;

  typedef struct {
    logic [63:0]  addr;
    logic [511:0] line;
    logic [19:0]  pid;
    logic [15:0]  tid;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[5];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  always @(negedge clock_i) begin
    if (cacheUpdate_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_update", 512'd1, 512'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("upd_addr", 512'(cacheUpdateAddress_o), 512'(e.addr));
        chk("upd_line", cacheUpdateLine_o, e.line);
        chk("upd_pid", 512'(cacheUpdatePid_o), 512'(e.pid));
        chk("upd_tid", 512'(cacheUpdateTid_o), 512'(e.tid));
      end
    end
  end

  task automatic run_vec(input vec_t v);
    exp_t e;
    if (v.stray) begin
      l2RespValid_i = 1'b1;
      l2RespData_i  = {4{$urandom}};
      @(negedge clock_i);
    end
    cacheMiss_i     = 1'b1;
    missedAddress_i = v.addr;
    missedPid_i     = v.pid;
    missedTid_i     = v.tid;
    l2ReqReady_i    = 1'b1;
    @(negedge clock_i);
    cacheMiss_i     = 1'b0;
    missedAddress_i = '0;
    chk("req_valid", 512'(l2ReqValid_o), 512'd1);
    chk("req_addr", 512'(l2ReqAddress_o), 512'(v.exp_addr));
    l2RespValid_i = v.stray;
    for (int d = 0; d < v.ready_delay; d++) begin
      l2ReqReady_i = 1'b0;
      @(negedge clock_i);
      chk("req_held", 512'({l2ReqValid_o, l2ReqAddress_o}), 512'({1'b1, v.exp_addr}));
    end
    l2ReqReady_i = 1'b1;
    @(negedge clock_i);
    l2ReqReady_i  = 1'b0;
    l2RespValid_i = 1'b0;
    chk("fill_state", 512'({busy_o, l2ReqValid_o}), 512'(2'b10));
    e.addr = v.exp_addr;
    e.line = v.line;
    e.pid  = v.pid;
    e.tid  = v.tid;
    sb.push_back(e);
    for (int k = 0; k < 4; k++) begin
      l2RespValid_i = 1'b1;
      l2RespData_i  = v.line[511-128*k -: 128];
      if (v.busy_miss && k == 2) begin
        cacheMiss_i     = 1'b1;
        missedAddress_i = 64'h4000;
      end
      @(negedge clock_i);
      l2RespValid_i = 1'b0;
      l2RespData_i  = {4{$urandom}};
      cacheMiss_i   = 1'b0;
      if (k == 1) begin
        for (int g = 0; g < v.gap; g++) begin
          @(negedge clock_i);
          chk("gap_no_update", 512'(cacheUpdate_o), 512'd0);
        end
      end
    end
    if (v.upd_miss) begin
      cacheMiss_i     = 1'b1;
      missedAddress_i = 64'h8000;
    end
    @(negedge clock_i);
    cacheMiss_i = 1'b0;
    chk("post_update_low", 512'(cacheUpdate_o), 512'd0);
    chk("post_idle", 512'({busy_o, l2ReqValid_o}), 512'd0);
    chk("update_consumed", 512'(sb.size()), 512'd0);
  endtask

  initial begin
    vec_t r;
    vecs[0] = '{64'h128, 20'h12345, 16'hBEEF, 0, 0, 1'b0, 1'b0, 1'b0, 64'h100,
                {{32{4'hA}}, {32{4'hB}}, {32{4'hC}}, {32{4'hD}}}};
    vecs[1] = '{64'hDEAD_BEEF_CAFE_F00D, 20'hABCDE, 16'h0001, 3, 2, 1'b0, 1'b0, 1'b0,
                64'hDEAD_BEEF_CAFE_F000,
                {128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 128'h8899_AABB_CCDD_EEFF_1357_9BDF_2468_ACE0,
                 128'hFFFF_0000_FFFF_0000_1234_5678_9ABC_DEF0, 128'h0F0F_F0F0_A5A5_5A5A_C3C3_3C3C_9696_6969}};
    vecs[2] = '{64'h13F, 20'h00042, 16'h7777, 0, 1, 1'b0, 1'b1, 1'b0, 64'h100,
                {{32{4'h1}}, {32{4'h2}}, {32{4'h3}}, {32{4'h4}}}};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 20'hFFFFF, 16'hFFFF, 1, 0, 1'b1, 1'b0, 1'b1,
                64'hFFFF_FFFF_FFFF_FFC0,
                {{32{4'h5}}, {32{4'h6}}, {32{4'h7}}, {32{4'h8}}}};
    vecs[4] = '{64'h4000, 20'h00009, 16'h0009, 0, 0, 1'b0, 1'b0, 1'b0, 64'h4000,
                {{32{4'hE}}, {32{4'hF}}, {32{4'h9}}, {32{4'h0}}}};

    repeat (2) @(negedge clock_i);
    chk("reset_outputs", 512'({busy_o, l2ReqValid_o, cacheUpdate_o, l2ReqAddress_o}), 512'd0);
    chk("reset_line", cacheUpdateLine_o, 512'd0);
    reset_i = 1'b1;
    @(negedge clock_i);

    for (int i = 0; i < 4; i++) begin
      run_vec(vecs[i]);
      repeat (2) @(negedge clock_i);
      chk("idle_after_vec", 512'({busy_o, l2ReqValid_o}), 512'd0);
    end

    cacheMiss_i     = 1'b1;
    missedAddress_i = 64'h2000;
    missedPid_i     = 20'h55555;
    missedTid_i     = 16'h5555;
    @(negedge clock_i);
    cacheMiss_i  = 1'b0;
    l2ReqReady_i = 1'b1;
    @(negedge clock_i);
    l2ReqReady_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      l2RespValid_i = 1'b1;
      l2RespData_i  = {32{4'h3}};
      @(negedge clock_i);
      l2RespValid_i = 1'b0;
    end
    #3 reset_i = 1'b0;
    #1;
    chk("midreset_ctrl", 512'({busy_o, l2ReqValid_o, cacheUpdate_o}), 512'd0);
    chk("midreset_addr", 512'({l2ReqAddress_o, cacheUpdateAddress_o}), 512'd0);
    chk("midreset_line", cacheUpdateLine_o, 512'd0);
    @(negedge clock_i);
    reset_i = 1'b1;
    repeat (6) @(negedge clock_i);
    chk("midreset_no_update", 512'(sb.size()), 512'd0);

    r = vecs[4];
    run_vec(r);
    repeat (3) @(negedge clock_i);
    chk("final_queue_empty", 512'(sb.size()), 512'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
